account_server: RTL and testbench

ACCOUNT_SERVER -- requirements
Module: account_server

---
 rtl/account_server.sv | 191 +++++++++++++++++++
 tb/tb_account_server.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/account_server.sv
// Account server: 4-state request FSM over per-account balance/PIN tables, 3-cycle request-to-response.
// Optional macro ACCOUNT_SERVER_LOCKOUT_EN locks an account after 3 consecutive wrong PINs.
module account_server #(
  parameter int         NUM_ACCOUNTS = 10,
  parameter logic [4:0] INIT_BALANCE = 5'd20,
  parameter logic [3:0] PIN_BASE     = 4'd3
) (
  input  logic       Clock,
  input  logic       Clear_n,
  input  logic       ReqValid,
  output logic       ReqReady,
  input  logic [1:0] ReqOp,
  input  logic [3:0] ReqID,
  input  logic [3:0] ReqPassword,
  input  logic [4:0] ReqValue,
  output logic       RespValid,
  input  logic       RespReady,
  output logic [2:0] RespStatus,
  output logic [4:0] RespBalance
);

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, RESPOND} state_e;
  typedef enum logic [2:0] {
    ST_OK         = 3'd0,
    ST_ERR_ID     = 3'd1,
    ST_ERR_PASS   = 3'd2,
    ST_ERR_FUNDS  = 3'd3,
    ST_ERR_OVF    = 3'd4,
    ST_ERR_LOCKED = 3'd5
  } status_e;

  localparam logic [1:0] OP_BALANCE  = 2'b00;
  localparam logic [1:0] OP_WITHDRAW = 2'b01;
  localparam logic [1:0] OP_DEPOSIT  = 2'b10;
  localparam logic [1:0] OP_CHPIN    = 2'b11;

  state_e     state_q, state_d;
  logic [1:0] op_q;
  logic [3:0] id_q, pwd_q;
  logic [4:0] val_q;

  logic       id_ok_q, look_lock_q;
  logic [4:0] look_bal_q;
  logic [3:0] look_pin_q;

  logic [4:0] acct_bal_q [NUM_ACCOUNTS];
  logic [3:0] acct_pin_q [NUM_ACCOUNTS];

  status_e    resp_status_q;
  logic [4:0] resp_bal_q;

  logic       accept, id_ok_c, locked_c;
  status_e    upd_status;
  logic [4:0] upd_bal, resp_bal_c;
  logic [5:0] sum6;
  logic       wr_bal, wr_pin;

  assign ReqReady    = (state_q == IDLE);
  assign RespValid   = (state_q == RESPOND);
  assign RespStatus  = resp_status_q;
  assign RespBalance = resp_bal_q;

  assign accept  = ReqValid && (state_q == IDLE);
  assign id_ok_c = (int'(id_q) < NUM_ACCOUNTS);
  assign sum6    = {1'b0, look_bal_q} + {1'b0, val_q};

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOOKUP;
      LOOKUP:  state_d = UPDATE;
      UPDATE:  state_d = RESPOND;
      RESPOND: if (RespReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      op_q  <= '0;
      id_q  <= '0;
      pwd_q <= '0;
      val_q <= '0;
    end else if (accept) begin
      op_q  <= ReqOp;
      id_q  <= ReqID;
      pwd_q <= ReqPassword;
      val_q <= ReqValue;
    end
  end

  // Table reads are guarded by the ID check so an out-of-range ID never indexes the tables.
  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      id_ok_q     <= 1'b0;
      look_lock_q <= 1'b0;
      look_bal_q  <= '0;
      look_pin_q  <= '0;
    end else if (state_q == LOOKUP) begin
      id_ok_q     <= id_ok_c;
      look_lock_q <= locked_c;
      look_bal_q  <= id_ok_c ? acct_bal_q[id_q] : 5'd0;
      look_pin_q  <= id_ok_c ? acct_pin_q[id_q] : 4'd0;
    end
  end

  always_comb begin
    upd_status = ST_OK;
    upd_bal    = look_bal_q;
    wr_bal     = 1'b0;
    wr_pin     = 1'b0;
    if (!id_ok_q)                 upd_status = ST_ERR_ID;
    else if (look_lock_q)         upd_status = ST_ERR_LOCKED;
    else if (pwd_q != look_pin_q) upd_status = ST_ERR_PASS;
    else begin
      case (op_q)
        OP_WITHDRAW: begin
          if (val_q > look_bal_q) upd_status = ST_ERR_FUNDS;
          else begin
            upd_bal = look_bal_q - val_q;
            wr_bal  = 1'b1;
          end
        end
        OP_DEPOSIT: begin
          if (sum6 > 6'd31) upd_status = ST_ERR_OVF;
          else begin
            upd_bal = sum6[4:0];
            wr_bal  = 1'b1;
          end
        end
        OP_CHPIN:   wr_pin = 1'b1;
        OP_BALANCE: upd_status = ST_OK;
        default:    upd_status = ST_OK;
      endcase
    end
    resp_bal_c = (upd_status == ST_OK || upd_status == ST_ERR_FUNDS ||
                  upd_status == ST_ERR_OVF) ? upd_bal : 5'd0;
  end

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      resp_status_q <= ST_OK;
      resp_bal_q    <= '0;
    end else if (state_q == UPDATE) begin
      resp_status_q <= upd_status;
      resp_bal_q    <= resp_bal_c;
    end
  end

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        acct_bal_q[i] <= INIT_BALANCE;
        acct_pin_q[i] <= PIN_BASE + 4'(i);
      end
    end else if (state_q == UPDATE) begin
      if (wr_bal) acct_bal_q[id_q] <= upd_bal;
      if (wr_pin) acct_pin_q[id_q] <= val_q[3:0];
    end
  end

`ifdef ACCOUNT_SERVER_LOCKOUT_EN
  logic [1:0]              fail_cnt_q [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] lock_q;

  assign locked_c = id_ok_c && lock_q[id_q];

  // Third consecutive wrong PIN still reports ERR_PASS but locks the account for later requests.
  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      lock_q <= '0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) fail_cnt_q[i] <= 2'd0;
    end else if (state_q == UPDATE && id_ok_q) begin
      if (upd_status == ST_ERR_PASS) begin
        if (fail_cnt_q[id_q] == 2'd2) lock_q[id_q] <= 1'b1;
        if (fail_cnt_q[id_q] != 2'd3) fail_cnt_q[id_q] <= fail_cnt_q[id_q] + 2'd1;
      end else if (upd_status == ST_OK) begin
        fail_cnt_q[id_q] <= 2'd0;
      end
    end
  end
`else
  assign locked_c = 1'b0;
`endif

endmodule

// File: tb/tb_account_server.sv
// Directed self-checking bench for account_server; expectations follow the configured lockout macro.
module tb_account_server;
  logic       Clock = 1'b0;
  logic       Clear_n;
  logic       ReqValid, ReqReady, RespValid, RespReady;
  logic [1:0] ReqOp;
  logic [3:0] ReqID, ReqPassword;
  logic [4:0] ReqValue, RespBalance;
  logic [2:0] RespStatus;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  account_server dut (
    .Clock(Clock), .Clear_n(Clear_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp), .ReqID(ReqID),
    .ReqPassword(ReqPassword), .ReqValue(ReqValue),
    .RespValid(RespValid), .RespReady(RespReady),
    .RespStatus(RespStatus), .RespBalance(RespBalance)
  );

  task automatic drive_req(input logic [1:0] op, input logic [3:0] id,
                           input logic [3:0] pwd, input logic [4:0] val);
    ReqOp = op; ReqID = id; ReqPassword = pwd; ReqValue = val; ReqValid = 1'b1;
  endtask

  task automatic wait_resp(output logic got, output int lat);
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      lat++;
      if (RespValid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic consume();
    RespReady = 1'b1;
    @(posedge Clock);
    #1 RespReady = 1'b0;
  endtask

  task automatic txn(input logic [1:0] op, input logic [3:0] id, input logic [3:0] pwd,
                     input logic [4:0] val, output logic got, output int lat,
                     output logic [2:0] st, output logic [4:0] bal);
    @(posedge Clock);
    #1 drive_req(op, id, pwd, val);
    @(posedge Clock);
    #1 ReqValid = 1'b0;
    wait_resp(got, lat);
    st  = RespStatus;
    bal = RespBalance;
    if (got) consume();
  endtask

  task automatic test_reset();
    Clear_n = 1'b0; ReqValid = 1'b0; RespReady = 1'b0;
    ReqOp = '0; ReqID = '0; ReqPassword = '0; ReqValue = '0;
    #23 Clear_n = 1'b1;
    @(negedge Clock);
    n_checks++;
    if (ReqReady !== 1'b1 || RespValid !== 1'b0 || RespStatus !== 3'd0 || RespBalance !== 5'd0) begin
      n_fail++;
      $display("FAIL reset: rdy=%b vld=%b st=%0d bal=%0d, want rdy=1 vld=0 st=0 bal=0",
               ReqReady, RespValid, RespStatus, RespBalance);
    end
  endtask

  task automatic test_balance_query();
    logic got; int lat; logic [2:0] st; logic [4:0] bal;
    txn(2'b00, 4'd2, 4'd5, 5'd0, got, lat, st, bal);
    n_checks++;
    if (!got || lat !== 3) begin
      n_fail++;
      $display("FAIL query_latency: got=%b lat=%0d, want got=1 lat=3", got, lat);
    end
    n_checks++;
    if (st !== 3'd0 || bal !== 5'd20) begin
      n_fail++;
      $display("FAIL query_id2: st=%0d bal=%0d, want st=0 bal=20", st, bal);
    end
  endtask

  task automatic test_withdraw();
    logic got; int lat; logic [2:0] st; logic [4:0] bal;
    txn(2'b01, 4'd2, 4'd5, 5'd7, got, lat, st, bal);
    n_checks++;
    if (!got || st !== 3'd0 || bal !== 5'd13) begin
      n_fail++;
      $display("FAIL withdraw7: got=%b st=%0d bal=%0d, want st=0 bal=13", got, st, bal);
    end
    txn(2'b01, 4'd2, 4'd5, 5'd14, got, lat, st, bal);
    n_checks++;
    if (!got || st !== 3'd3 || bal !== 5'd13) begin
      n_fail++;
      $display("FAIL withdraw14: got=%b st=%0d bal=%0d, want st=3 bal=13", got, st, bal);
    end
    txn(2'b01, 4'd2, 4'd5, 5'd0, got, lat, st, bal);
    n_checks++;
    if (!got || st !== 3'd0 || bal !== 5'd13) begin
      n_fail++;
      $display("FAIL withdraw0: got=%b st=%0d bal=%0d, want st=0 bal=13", got, st, bal);
    end
  endtask

  task automatic test_deposit_and_pin();
    logic got; int lat; logic [2:0] st; logic [4:0] bal;
    txn(2'b10, 4'd4, 4'd7, 5'd12, got, lat, st, bal);
    n_checks++;
    if (!got || st !== 3'd4 || bal !== 5'd20) begin
      n_fail++;
      $display("FAIL deposit12: got=%b st=%0d bal=%0d, want st=4 bal=20", got, st, bal);
    end
    txn(2'b10, 4'd4, 4'd7, 5'd11, got, lat, st, bal);
    n_checks++;
    if (!got || st !== 3'd0 || bal !== 5'd31) begin
      n_fail++;
      $display("FAIL deposit11: got=%b st=%0d bal=%0d, want st=0 bal=31", got, st, bal);
    end
    txn(2'b11, 4'd5, 4'd8, 5'd9, got, lat, st, bal);
    n_checks++;
    if (!got || st !== 3'd0 || bal !== 5'd20) begin
      n_fail++;
      $display("FAIL chpin: got=%b st=%0d bal=%0d, want st=0 bal=20", got, st, bal);
    end
    txn(2'b00, 4'd5, 4'd8, 5'd0, got, lat, st, bal);
    n_checks++;
    if (!got || st !== 3'd2 || bal !== 5'd0) begin
      n_fail++;
      $display("FAIL old_pin: got=%b st=%0d bal=%0d, want st=2 bal=0", got, st, bal);
    end
    txn(2'b00, 4'd5, 4'd9, 5'd0, got, lat, st, bal);
    n_checks++;
    if (!got || st !== 3'd0 || bal !== 5'd20) begin
      n_fail++;
      $display("FAIL new_pin: got=%b st=%0d bal=%0d, want st=0 bal=20", got, st, bal);
    end
  endtask

  task automatic test_back_to_back();
    logic got; int lat; int busy_rdy;
    @(posedge Clock);
    #1 drive_req(2'b00, 4'd10, 4'd0, 5'd0);
    @(posedge Clock);
    // Second request replaces the fields and stays valid while the first is in flight.
    #1 drive_req(2'b00, 4'd0, 4'd3, 5'd0);
    busy_rdy = 0;
    wait_resp(got, lat);
    n_checks++;
    if (!got || RespStatus !== 3'd1 || RespBalance !== 5'd0) begin
      n_fail++;
      $display("FAIL bad_id: got=%b st=%0d bal=%0d, want st=1 bal=0", got, RespStatus, RespBalance);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      if (ReqReady !== 1'b0) busy_rdy++;
    end
    n_checks++;
    if (busy_rdy != 0) begin
      n_fail++;
      $display("FAIL busy_ready: ReqReady high %0d times while busy, want 0", busy_rdy);
    end
    consume();
    @(negedge Clock);
    n_checks++;
    if (ReqReady !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_after_resp: ReqReady=%b, want 1", ReqReady);
    end
    @(posedge Clock);
    #1 ReqValid = 1'b0;
    n_checks++;
    if (ReqReady !== 1'b0) begin
      n_fail++;
      $display("FAIL second_accept: ReqReady=%b after accept edge, want 0", ReqReady);
    end
    wait_resp(got, lat);
    n_checks++;
    if (!got || lat !== 3 || RespStatus !== 3'd0 || RespBalance !== 5'd20) begin
      n_fail++;
      $display("FAIL second_req: got=%b lat=%0d st=%0d bal=%0d, want lat=3 st=0 bal=20",
               got, lat, RespStatus, RespBalance);
    end
    if (got) consume();
    busy_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      if (ReqReady !== 1'b1 || RespValid !== 1'b0) busy_rdy++;
    end
    n_checks++;
    if (busy_rdy != 0) begin
      n_fail++;
      $display("FAIL no_double_accept: %0d busy cycles after last response, want 0", busy_rdy);
    end
  endtask

  task automatic test_pin_lockout();
    logic got; int lat; logic [2:0] st; logic [4:0] bal;
    for (int i = 0; i < 3; i++) begin
      txn(2'b00, 4'd1, 4'd0, 5'd0, got, lat, st, bal);
      n_checks++;
      if (!got || st !== 3'd2 || bal !== 5'd0) begin
        n_fail++;
        $display("FAIL wrong_pin_%0d: got=%b st=%0d bal=%0d, want st=2 bal=0", i, got, st, bal);
      end
    end
    txn(2'b00, 4'd1, 4'd4, 5'd0, got, lat, st, bal);
    n_checks++;
`ifdef ACCOUNT_SERVER_LOCKOUT_EN
    if (!got || st !== 3'd5 || bal !== 5'd0) begin
      n_fail++;
      $display("FAIL locked: got=%b st=%0d bal=%0d, want st=5 bal=0", got, st, bal);
    end
`else
    if (!got || st !== 3'd0 || bal !== 5'd20) begin
      n_fail++;
      $display("FAIL no_lockout: got=%b st=%0d bal=%0d, want st=0 bal=20", got, st, bal);
    end
`endif
  endtask

  task automatic test_resp_stall();
    logic got; int lat; int bad;
    @(posedge Clock);
    #1 drive_req(2'b00, 4'd0, 4'd3, 5'd0);
    @(posedge Clock);
    #1 ReqValid = 1'b0;
    wait_resp(got, lat);
    bad = got ? 0 : 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      if (RespValid !== 1'b1 || RespStatus !== 3'd0 || RespBalance !== 5'd20) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL resp_stall: %0d unstable cycles (vld=%b st=%0d bal=%0d), want 0",
               bad, RespValid, RespStatus, RespBalance);
    end
    consume();
  endtask

  task automatic test_reset_in_update();
    logic got; int lat; logic [2:0] st; logic [4:0] bal;
    @(posedge Clock);
    #1 drive_req(2'b01, 4'd3, 4'd6, 5'd5);
    @(posedge Clock);
    #1 ReqValid = 1'b0;
    @(posedge Clock);
    #2 Clear_n = 1'b0;
    #1;
    n_checks++;
    if (RespValid !== 1'b0 || ReqReady !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: vld=%b rdy=%b, want vld=0 rdy=1", RespValid, ReqReady);
    end
    @(negedge Clock);
    Clear_n = 1'b1;
    @(negedge Clock);
    n_checks++;
    if (RespValid !== 1'b0) begin
      n_fail++;
      $display("FAIL aborted_resp: vld=%b, want 0", RespValid);
    end
    txn(2'b00, 4'd3, 4'd6, 5'd0, got, lat, st, bal);
    n_checks++;
    if (!got || st !== 3'd0 || bal !== 5'd20) begin
      n_fail++;
      $display("FAIL aborted_write: got=%b st=%0d bal=%0d, want st=0 bal=20", got, st, bal);
    end
  endtask

  initial begin
    RespReady = 1'b0;
    test_reset();
    test_balance_query();
    test_withdraw();
    test_deposit_and_pin();
    test_back_to_back();
    test_pin_lockout();
    test_resp_stall();
    test_reset_in_update();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
